// File: rtl/ef_bus_arbiter.sv
// Flash / LAN91C111 shared async bus arbiter with programmable strobe timing.
// Optional: define EF_ARB_FLASH_RDY_EN to stall flash SETUP on flash_ry_by_n.
module ef_bus_arbiter #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_HOLD   = 1,
    parameter int unsigned T_TURN   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fl_req,
    input  logic        fl_we,
    input  logic [22:0] fl_adr,
    input  logic [31:0] fl_wdat,
    output logic [31:0] fl_rdat,
    output logic        fl_ack,
    input  logic        en_req,
    input  logic        en_we,
    input  logic [22:0] en_adr,
    input  logic [3:0]  en_be,
    input  logic [31:0] en_wdat,
    output logic [31:0] en_rdat,
    output logic        en_ack,
    output logic [22:0] ef_a,
    output logic [31:0] ef_d_o,
    output logic        ef_d_oe,
    input  logic [31:0] ef_d_i,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        enet_rd_n,
    output logic        enet_wr_n,
    output logic [3:0]  enet_be_n,
    input  logic        flash_ry_by_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_TURN
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_n;

    // r_gnt_en / r_rr_en: 1 = ethernet, 0 = flash
    logic        r_gnt_en;
    logic        r_rr_en;
    logic        r_we;
    logic [22:0] r_adr;
    logic [3:0]  r_be;
    logic [31:0] r_wdat;
    logic        r_fl_ack;
    logic        r_en_ack;
    logic [31:0] r_fl_rdat;
    logic [31:0] r_en_rdat;

    logic        w_fl_vld;
    logic        w_en_vld;
    logic        w_any;
    logic        w_pick_en;
    logic        w_cnt_zero;
    logic        w_other;
    logic        w_turn;
    logic        w_rdy_hold;
    logic        w_act;
    logic        w_strb;
    logic        w_last_strb;
    logic        w_last_hold;

    // A port being acked this cycle still shows req; it must not be re-granted
    assign w_fl_vld    = fl_req && !r_fl_ack;
    assign w_en_vld    = en_req && !r_en_ack;
    assign w_any       = w_fl_vld || w_en_vld;
    assign w_pick_en   = w_en_vld && (!w_fl_vld || !r_rr_en);
    assign w_cnt_zero  = (r_cnt == 4'd0);
    assign w_other     = r_gnt_en ? fl_req : en_req;
    assign w_turn      = (!r_we || w_other) && (T_TURN != 0);
    assign w_act       = (r_state == S_SETUP) || (r_state == S_STROBE)
                       || (r_state == S_HOLD);
    assign w_strb      = (r_state == S_STROBE);
    assign w_last_strb = w_strb && w_cnt_zero;
    assign w_last_hold = (r_state == S_HOLD) && w_cnt_zero;

`ifdef EF_ARB_FLASH_RDY_EN
    assign w_rdy_hold = !r_gnt_en && !flash_ry_by_n;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = flash_ry_by_n;
    assign w_rdy_hold   = 1'b0;
`endif

    // Next-state and phase counter reload
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_cnt_zero ? 4'd0 : r_cnt - 4'd1;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = 4'd0;
                if (w_any) begin
                    w_state_n = S_SETUP;
                    w_cnt_n   = 4'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (w_rdy_hold) begin
                    w_cnt_n = 4'(T_SETUP - 1);
                end else if (w_cnt_zero) begin
                    w_state_n = S_STROBE;
                    w_cnt_n   = 4'(T_STROBE - 1);
                end
            end
            S_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_n = S_HOLD;
                    w_cnt_n   = 4'(T_HOLD - 1);
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    if (w_turn) begin
                        w_state_n = S_TURN;
                        w_cnt_n   = 4'(T_TURN - 1);
                    end else begin
                        w_state_n = S_IDLE;
                        w_cnt_n   = 4'd0;
                    end
                end
            end
            S_TURN: begin
                if (w_cnt_zero) begin
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 4'd0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Latch the granted request when leaving IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_en <= 1'b0;
            r_rr_en  <= 1'b1;
            r_we     <= 1'b0;
            r_adr    <= 23'd0;
            r_be     <= 4'd0;
            r_wdat   <= 32'd0;
        end else if ((r_state == S_IDLE) && w_any) begin
            r_gnt_en <= w_pick_en;
            r_rr_en  <= w_pick_en;
            r_we     <= w_pick_en ? en_we   : fl_we;
            r_adr    <= w_pick_en ? en_adr  : fl_adr;
            r_be     <= w_pick_en ? en_be   : 4'hF;
            r_wdat   <= w_pick_en ? en_wdat : fl_wdat;
        end
    end

    // Completion pulses and per-port read data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fl_ack  <= 1'b0;
            r_en_ack  <= 1'b0;
            r_fl_rdat <= 32'd0;
            r_en_rdat <= 32'd0;
        end else begin
            r_fl_ack <= w_last_hold && !r_gnt_en;
            r_en_ack <= w_last_hold && r_gnt_en;
            if (w_last_strb && !r_we) begin
                if (r_gnt_en) begin
                    r_en_rdat <= ef_d_i;
                end else begin
                    r_fl_rdat <= ef_d_i;
                end
            end
        end
    end

    assign fl_ack     = r_fl_ack;
    assign en_ack     = r_en_ack;
    assign fl_rdat    = r_fl_rdat;
    assign en_rdat    = r_en_rdat;
    assign ef_a       = r_adr;
    assign ef_d_o     = r_wdat;
    assign ef_d_oe    = w_act && r_we;
    assign flash_ce_n = !(w_act && !r_gnt_en);
    assign flash_oe_n = !(w_strb && !r_gnt_en && !r_we);
    assign flash_we_n = !(w_strb && !r_gnt_en && r_we);
    assign enet_rd_n  = !(w_strb && r_gnt_en && !r_we);
    assign enet_wr_n  = !(w_strb && r_gnt_en && r_we);
    assign enet_be_n  = (w_act && r_gnt_en) ? ~r_be : 4'hF;

endmodule

// File: tb/tb_ef_bus_arbiter.sv
// Directed bench for ef_bus_arbiter at default timing.
// Define EF_ARB_FLASH_RDY_EN to include the flash ready stall case.
module tb_ef_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fl_req, fl_we;
    logic [22:0] fl_adr;
    logic [31:0] fl_wdat, fl_rdat;
    logic        fl_ack;
    logic        en_req, en_we;
    logic [22:0] en_adr;
    logic [3:0]  en_be;
    logic [31:0] en_wdat, en_rdat;
    logic        en_ack;
    logic [22:0] ef_a;
    logic [31:0] ef_d_o, ef_d_i;
    logic        ef_d_oe;
    logic        flash_ce_n, flash_oe_n, flash_we_n;
    logic        enet_rd_n, enet_wr_n;
    logic [3:0]  enet_be_n;
    logic        flash_ry_by_n;

    int n_chk  = 0;
    int n_fail = 0;

    ef_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .fl_req(fl_req), .fl_we(fl_we), .fl_adr(fl_adr),
        .fl_wdat(fl_wdat), .fl_rdat(fl_rdat), .fl_ack(fl_ack),
        .en_req(en_req), .en_we(en_we), .en_adr(en_adr),
        .en_be(en_be), .en_wdat(en_wdat), .en_rdat(en_rdat),
        .en_ack(en_ack), .ef_a(ef_a), .ef_d_o(ef_d_o),
        .ef_d_oe(ef_d_oe), .ef_d_i(ef_d_i),
        .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n), .enet_rd_n(enet_rd_n),
        .enet_wr_n(enet_wr_n), .enet_be_n(enet_be_n),
        .flash_ry_by_n(flash_ry_by_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic got;
        rst_n = 1'b0;
        fl_req = 0; fl_we = 0; fl_adr = '0; fl_wdat = '0;
        en_req = 0; en_we = 0; en_adr = '0; en_be = '0; en_wdat = '0;
        ef_d_i = '0; flash_ry_by_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // reset state
        check("rst_strb", {flash_ce_n, flash_oe_n, flash_we_n,
              enet_rd_n, enet_wr_n, enet_be_n}, 32'h1FF);
        check("rst_a", ef_a, 0);
        check("rst_do", ef_d_o, 0);
        check("rst_oe", ef_d_oe, 0);
        check("rst_ack", {fl_ack, en_ack}, 0);
        check("rst_frd", fl_rdat, 0);
        check("rst_erd", en_rdat, 0);
        rst_n = 1'b1;
        step;

        // flash read
        fl_req = 1; fl_we = 0; fl_adr = 23'h000100;
        ef_d_i = 32'hCAFE_F00D;
        for (int c = 1; c <= 9; c++) begin
            step;
            check("t1_ce", flash_ce_n, (c >= 1 && c <= 7) ? 0 : 1);
            check("t1_oe", flash_oe_n, (c >= 3 && c <= 6) ? 0 : 1);
            check("t1_we", flash_we_n, 1);
            check("t1_doe", ef_d_oe, 0);
            check("t1_ack", fl_ack, (c == 8) ? 1 : 0);
            check("t1_ebe", enet_be_n, 4'hF);
            if (c == 1) check("t1_a", ef_a, 23'h000100);
            if (c == 8) begin
                check("t1_rdat", fl_rdat, 32'hCAFE_F00D);
                fl_req = 0;
            end
        end
        repeat (2) step;

        // ethernet write, then flash read straight after: no TURN
        en_req = 1; en_we = 1; en_adr = 23'h000300;
        en_be = 4'b0011; en_wdat = 32'h1234_5678;
        for (int c = 1; c <= 8; c++) begin
            step;
            check("t2_be", enet_be_n, (c <= 7) ? 4'b1100 : 4'b1111);
            check("t2_doe", ef_d_oe, (c <= 7) ? 1 : 0);
            check("t2_wr", enet_wr_n, (c >= 3 && c <= 6) ? 0 : 1);
            check("t2_rd", enet_rd_n, 1);
            check("t2_ce", flash_ce_n, 1);
            check("t2_ack", en_ack, (c == 8) ? 1 : 0);
            if (c == 1) begin
                check("t2_do", ef_d_o, 32'h1234_5678);
                check("t2_a", ef_a, 23'h000300);
            end
        end
        en_req = 0;
        fl_req = 1; fl_we = 0; fl_adr = 23'h000123;
        ef_d_i = 32'h0BAD_BEEF;
        step;
        check("t2_noturn", flash_ce_n, 0);
        k = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step;
            if (fl_ack) begin
                got = 1;
                k = i + 10;
            end
        end
        fl_req = 0;
        check("t2_fl_ack_cyc", k, 16);
        check("t2_fl_rdat", fl_rdat, 32'h0BAD_BEEF);
        check("t2_erd_keep", en_rdat, 0);

        // contention after reset: F first, acks 10 cycles apart
        rst_n = 0;
        step;
        rst_n = 1;
        step;
        fl_req = 1; fl_we = 1; fl_wdat = 32'hAAAA_0001;
        en_req = 1; en_we = 1; en_wdat = 32'h5555_0002; en_be = 4'hF;
        for (int c = 1; c <= 40; c++) begin
            step;
            check("t3_flack", fl_ack, (c == 8 || c == 28) ? 1 : 0);
            check("t3_enack", en_ack, (c == 18 || c == 38) ? 1 : 0);
            check("t3_onecs", !flash_ce_n && (enet_be_n != 4'hF), 0);
            if (c == 1 || c == 21)
                check("t3_do_f", ef_d_o, 32'hAAAA_0001);
            if (c == 11 || c == 31)
                check("t3_do_e", ef_d_o, 32'h5555_0002);
        end
        fl_req = 0;
        en_req = 0;
        repeat (3) step;

        // flash read, then write on the same port after ack
        fl_req = 1; fl_we = 0; fl_adr = 23'h000055;
        ef_d_i = 32'h1357_9BDF;
        for (int c = 1; c <= 18; c++) begin
            step;
            check("t4_ce", flash_ce_n,
                  ((c >= 1 && c <= 7) || (c >= 11 && c <= 17)) ? 0 : 1);
            check("t4_doe", ef_d_oe, (c >= 11 && c <= 17) ? 1 : 0);
            check("t4_ack", fl_ack, (c == 8 || c == 18) ? 1 : 0);
            if (c == 8) begin
                check("t4_rdat", fl_rdat, 32'h1357_9BDF);
                fl_req = 0;
            end
            if (c == 9) begin
                fl_req = 1; fl_we = 1; fl_wdat = 32'hFEED_0004;
            end
            if (c == 18) fl_req = 0;
        end
        repeat (2) step;

        // async reset during STROBE
        fl_req = 1; fl_we = 1; fl_wdat = 32'h0000_00A5;
        repeat (4) step;
        check("t5_pre_we", flash_we_n, 0);
        #1 rst_n = 0;
        #1;
        check("t5_strb", {flash_ce_n, flash_oe_n, flash_we_n,
              enet_rd_n, enet_wr_n}, 5'h1F);
        check("t5_doe", ef_d_oe, 0);
        fl_req = 0;
        step;
        step;
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            step;
            check("t5_noack", fl_ack, 0);
        end

`ifdef EF_ARB_FLASH_RDY_EN
        // flash busy for 10 SETUP cycles delays ack by 10
        fl_req = 1; fl_we = 0; fl_adr = 23'h000777;
        ef_d_i = 32'h2468_ACE0;
        flash_ry_by_n = 0;
        for (int c = 1; c <= 18; c++) begin
            step;
            check("t6_ack", fl_ack, (c == 18) ? 1 : 0);
            check("t6_oe", flash_oe_n, (c >= 13 && c <= 16) ? 0 : 1);
            if (c == 11) flash_ry_by_n = 1;
            if (c == 18) begin
                check("t6_rdat", fl_rdat, 32'h2468_ACE0);
                fl_req = 0;
            end
        end
        repeat (3) step;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
